// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared types and constants for the data-memory arbiter:
//               FSM state encoding, funct3 access-size codes, the size of the
//               data memory and a helper that maps funct3 to a byte count.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte span of the data memory.
  localparam int DMEM_BYTES = 2**17;

  // Access size in bytes. Unused codes (011, 110, 111) are sized as words.
  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: size_bytes = 3'd1;
      F3_H, F3_HU: size_bytes = 3'd2;
      default:     size_bytes = 3'd4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin selector. A lone requester always wins;
//               with both requesting, the port not served last wins.
// Ports       : req[1:0] - request vector (bit 0 = p0, bit 1 = p1)
//               last     - port served last (0 = p0, 1 = p1)
//               grant    - one-hot winner, all zero when nobody requests
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Arbitrates two requesters (p0 = CPU load/store, p1 = debug /
//               loader) onto one data-memory port. Each access walks
//               IDLE -> ACCESS -> RESP: grant pulses combinationally in IDLE,
//               memory is driven from latched request fields in ACCESS, and
//               done (plus err) pulses in RESP.
// Ports       : clk, rst (async, active high)
//               pN_req/we/addr/wdata/funct3  - request side, N = 0/1
//               pN_gnt/done/err              - response pulses
//               rdata                        - last successful load result
//               mem_wr_en/addr/wdata/funct3  - memory command
//               mem_rdata                    - combinational memory read data
// Config      : `define DMEM_ARB_ALIGN_CHECK_EN enables the alignment /
//               range error check; otherwise err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     p0_req,
  input  logic                     p0_we,
  input  logic [ADDRESS_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0]    p0_wdata,
  input  logic [2:0]               p0_funct3,
  input  logic                     p1_req,
  input  logic                     p1_we,
  input  logic [ADDRESS_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0]    p1_wdata,
  input  logic [2:0]               p1_funct3,
  output logic                     p0_gnt,
  output logic                     p1_gnt,
  output logic                     p0_done,
  output logic                     p1_done,
  output logic                     p0_err,
  output logic                     p1_err,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     mem_wr_en,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic [2:0]               mem_funct3,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  arb_state_t               r_state;
  logic                     r_last;    // port served last: 0 = p0, 1 = p1
  logic                     r_sel;     // port owning the current access
  logic                     r_we;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [2:0]               r_funct3;
  logic [DATA_WIDTH-1:0]    r_rdata;
  logic                     r_p0_done;
  logic                     r_p1_done;
  logic                     r_p0_err;
  logic                     r_p1_err;

  logic [1:0]               w_req;
  logic [1:0]               w_grant;
  logic                     w_idle;
  logic                     w_access;
  logic                     w_err;

  assign w_req    = {p1_req, p0_req};
  assign w_idle   = (r_state == IDLE);
  assign w_access = (r_state == ACCESS);

  rr_arb2 u_rr_arb2 (
    .req   (w_req),
    .last  (r_last),
    .grant (w_grant)
  );

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  // One bit wider than the address so addr + size cannot wrap.
  localparam logic [ADDRESS_WIDTH:0] c_dmem_limit = (ADDRESS_WIDTH+1)'(DMEM_BYTES);

  logic [2:0]               w_size;
  logic [ADDRESS_WIDTH:0]   w_end;

  // The check runs on the latched fields, so it is stable through ACCESS.
  // addr + size - 1 >= limit is rewritten as addr + size > limit.
  always_comb begin
    w_size = size_bytes(r_funct3);
    w_end  = {1'b0, r_addr} + {{(ADDRESS_WIDTH-2){1'b0}}, w_size};
    w_err  = ((w_size == 3'd2) && r_addr[0]) ||
             ((w_size == 3'd4) && (r_addr[1:0] != 2'b00)) ||
             (w_end > c_dmem_limit);
  end
`else
  assign w_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;   // p1 counts as served last so p0 wins first
      r_sel     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_funct3  <= 3'b000;
      r_rdata   <= '0;
      r_p0_done <= 1'b0;
      r_p1_done <= 1'b0;
      r_p0_err  <= 1'b0;
      r_p1_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_req) begin
            r_sel    <= w_grant[1];
            r_we     <= w_grant[1] ? p1_we     : p0_we;
            r_addr   <= w_grant[1] ? p1_addr   : p0_addr;
            r_wdata  <= w_grant[1] ? p1_wdata  : p0_wdata;
            r_funct3 <= w_grant[1] ? p1_funct3 : p0_funct3;
            r_state  <= ACCESS;
          end
        end
        ACCESS: begin
          // Load data is taken here while the memory still sees r_addr.
          if (!r_we && !w_err) begin
            r_rdata <= mem_rdata;
          end
          r_p0_done <= ~r_sel;
          r_p1_done <= r_sel;
          r_p0_err  <= ~r_sel & w_err;
          r_p1_err  <= r_sel & w_err;
          r_state   <= RESP;
        end
        RESP: begin
          r_p0_done <= 1'b0;
          r_p1_done <= 1'b0;
          r_p0_err  <= 1'b0;
          r_p1_err  <= 1'b0;
          r_last    <= r_sel;
          r_state   <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Grant is combinational so a requester sees acceptance in its request cycle.
  assign p0_gnt     = w_idle & w_grant[0];
  assign p1_gnt     = w_idle & w_grant[1];
  assign p0_done    = r_p0_done;
  assign p1_done    = r_p1_done;
  assign p0_err     = r_p0_err;
  assign p1_err     = r_p1_err;
  assign rdata      = r_rdata;

  // Derived from the state register, so an async reset drops it at once.
  assign mem_wr_en  = w_access & r_we & ~w_err;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign mem_funct3 = r_funct3;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [2:0]  p0_funct3, p1_funct3;
  logic        p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err;
  logic [31:0] rdata;
  logic        mem_wr_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_funct3;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int wc0;

  dmem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .p0_req     (p0_req),
    .p0_we      (p0_we),
    .p0_addr    (p0_addr),
    .p0_wdata   (p0_wdata),
    .p0_funct3  (p0_funct3),
    .p1_req     (p1_req),
    .p1_we      (p1_we),
    .p1_addr    (p1_addr),
    .p1_wdata   (p1_wdata),
    .p1_funct3  (p1_funct3),
    .p0_gnt     (p0_gnt),
    .p1_gnt     (p1_gnt),
    .p0_done    (p0_done),
    .p1_done    (p1_done),
    .p0_err     (p0_err),
    .p1_err     (p1_err),
    .rdata      (rdata),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_funct3 (mem_funct3),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Count write strobes seen at each rising edge.
  always @(posedge clk) if (mem_wr_en === 1'b1) wr_cnt <= wr_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit port, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] f3);
    if (port == 1'b0) begin
      p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_funct3 = f3;
    end else begin
      p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_funct3 = f3;
    end
  endtask

  // Drop requests and scramble fields; latched values must not follow.
  task automatic release_inputs();
    p0_req = 1'b0; p0_we = 1'b1; p0_addr = 32'hFFFF_FFFF; p0_wdata = 32'h0; p0_funct3 = 3'b111;
    p1_req = 1'b0; p1_we = 1'b1; p1_addr = 32'hFFFF_FFFF; p1_wdata = 32'h0; p1_funct3 = 3'b111;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    mem_rdata = 32'h0;
    release_inputs();
    tick(); tick();
    chk("reset_p0_gnt", {31'b0, p0_gnt}, 32'd0);
    chk("reset_done", {30'b0, p0_done, p1_done}, 32'd0);
    chk("reset_wr_en", {31'b0, mem_wr_en}, 32'd0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    rst = 1'b0;

    // p0 store W 0x10000 then load W from the same address
    tick();
    wc0 = wr_cnt;
    drive(1'b0, 1'b1, 32'h0001_0000, 32'hDEAD_BEEF, 3'b010);
    #1;
    chk("st_p0_gnt", {31'b0, p0_gnt}, 32'd1);
    chk("st_p1_gnt", {31'b0, p1_gnt}, 32'd0);
    tick(); release_inputs(); #1;
    chk("st_wr_en", {31'b0, mem_wr_en}, 32'd1);
    chk("st_mem_addr", mem_addr, 32'h0001_0000);
    chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("st_mem_funct3", {29'b0, mem_funct3}, 32'd2);
    chk("st_gnt_in_access", {31'b0, p0_gnt}, 32'd0);
    chk("st_done_early", {31'b0, p0_done}, 32'd0);
    tick();
    chk("st_done", {31'b0, p0_done}, 32'd1);
    chk("st_err", {31'b0, p0_err}, 32'd0);
    chk("st_wr_en_resp", {31'b0, mem_wr_en}, 32'd0);
    tick();
    chk("st_done_clear", {31'b0, p0_done}, 32'd0);
    chk("st_wr_count", wr_cnt - wc0, 32'd1);

    wc0 = wr_cnt;
    mem_rdata = 32'h1234_5678;
    drive(1'b0, 1'b0, 32'h0001_0000, 32'h0, 3'b010);
    #1;
    chk("ld_p0_gnt", {31'b0, p0_gnt}, 32'd1);
    tick(); release_inputs(); #1;
    chk("ld_wr_en", {31'b0, mem_wr_en}, 32'd0);
    chk("ld_mem_addr", mem_addr, 32'h0001_0000);
    tick(); mem_rdata = 32'h0; #1;
    chk("ld_done", {31'b0, p0_done}, 32'd1);
    chk("ld_rdata", rdata, 32'h1234_5678);
    tick();
    chk("ld_no_write", wr_cnt - wc0, 32'd0);

    // Both ports requesting continuously from reset: p0, p1, p0, p1
    rst = 1'b1; tick(); rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0001_0010, 32'h0, 3'b010);
    drive(1'b1, 1'b0, 32'h0001_0020, 32'h0, 3'b010);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr%0d_p0_gnt", k), {31'b0, p0_gnt}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr%0d_p1_gnt", k), {31'b0, p1_gnt}, (k % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      chk($sformatf("rr%0d_access_gnt", k), {30'b0, p1_gnt, p0_gnt}, 32'd0);
      chk($sformatf("rr%0d_mem_addr", k), mem_addr, (k % 2 == 0) ? 32'h0001_0010 : 32'h0001_0020);
      tick();
      chk($sformatf("rr%0d_resp_gnt", k), {30'b0, p1_gnt, p0_gnt}, 32'd0);
      chk($sformatf("rr%0d_done", k), {30'b0, p1_done, p0_done},
          (k % 2 == 0) ? 32'd1 : 32'd2);
      tick(); #1;
    end
    release_inputs();

    // p1-only load BU at 0x10003
    mem_rdata = 32'h0000_00A5;
    drive(1'b1, 1'b0, 32'h0001_0003, 32'h0, 3'b100);
    #1;
    chk("p1_gnt", {31'b0, p1_gnt}, 32'd1);
    chk("p1_p0_gnt", {31'b0, p0_gnt}, 32'd0);
    tick(); release_inputs(); #1;
    chk("p1_mem_funct3", {29'b0, mem_funct3}, 32'd4);
    chk("p1_mem_addr", mem_addr, 32'h0001_0003);
    tick();
    chk("p1_done", {30'b0, p1_done, p0_done}, 32'd2);
    chk("p1_err", {31'b0, p1_err}, 32'd0);
    chk("p1_rdata", rdata, 32'h0000_00A5);
    tick();

    // Misaligned store H at 0x10001
    wc0 = wr_cnt;
    drive(1'b0, 1'b1, 32'h0001_0001, 32'h0000_BEEF, 3'b001);
    #1;
    chk("sh_gnt", {31'b0, p0_gnt}, 32'd1);
    tick(); release_inputs(); #1;
    chk("sh_wr_en", {31'b0, mem_wr_en}, ALIGN_EN ? 32'd0 : 32'd1);
    tick();
    chk("sh_done", {31'b0, p0_done}, 32'd1);
    chk("sh_err", {31'b0, p0_err}, ALIGN_EN ? 32'd1 : 32'd0);
    tick();
    chk("sh_wr_count", wr_cnt - wc0, ALIGN_EN ? 32'd0 : 32'd1);
    chk("sh_err_clear", {31'b0, p0_err}, 32'd0);

    // Load W at 0x1FFFE: misaligned and crosses the top of memory
    mem_rdata = 32'hFFFF_FFFF;
    drive(1'b0, 1'b0, 32'h0001_FFFE, 32'h0, 3'b010);
    tick(); release_inputs(); tick();
    chk("lw_top_err", {31'b0, p0_err}, ALIGN_EN ? 32'd1 : 32'd0);
    chk("lw_top_rdata", rdata, ALIGN_EN ? 32'h0000_00A5 : 32'hFFFF_FFFF);
    tick();

    // Load HU at 0x1FFFE: last byte is 0x1FFFF, inside memory
    mem_rdata = 32'h0000_BEEF;
    drive(1'b0, 1'b0, 32'h0001_FFFE, 32'h0, 3'b101);
    tick(); release_inputs(); tick();
    chk("lhu_top_err", {31'b0, p0_err}, 32'd0);
    chk("lhu_top_rdata", rdata, 32'h0000_BEEF);
    tick();

    // Load BU at 0x20000: first byte past memory
    mem_rdata = 32'h0000_0011;
    drive(1'b0, 1'b0, 32'h0002_0000, 32'h0, 3'b100);
    tick(); release_inputs(); tick();
    chk("lbu_out_err", {31'b0, p0_err}, ALIGN_EN ? 32'd1 : 32'd0);
    chk("lbu_out_rdata", rdata, ALIGN_EN ? 32'h0000_BEEF : 32'h0000_0011);
    tick();

    // Reset in the middle of a store access
    drive(1'b0, 1'b1, 32'h0001_0004, 32'hCAFE_F00D, 3'b010);
    #1;
    chk("rst_st_gnt", {31'b0, p0_gnt}, 32'd1);
    tick(); release_inputs(); #1;
    chk("rst_st_wr_en", {31'b0, mem_wr_en}, 32'd1);
    wc0 = wr_cnt;
    rst = 1'b1;
    #1;
    chk("rst_wr_en_drop", {31'b0, mem_wr_en}, 32'd0);
    tick();
    chk("rst_no_done", {30'b0, p1_done, p0_done}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    rst = 1'b0;
    chk("rst_no_write", wr_cnt - wc0, 32'd0);
    drive(1'b0, 1'b0, 32'h0001_0000, 32'h0, 3'b010);
    drive(1'b1, 1'b0, 32'h0001_0008, 32'h0, 3'b010);
    #1;
    chk("rst_first_p0_gnt", {31'b0, p0_gnt}, 32'd1);
    chk("rst_first_p1_gnt", {31'b0, p1_gnt}, 32'd0);
    tick(); release_inputs(); tick();
    chk("rst_first_done", {30'b0, p1_done, p0_done}, 32'd1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports p0_req and p1_req, input, 1 bit each: access request; p0 is the CPU load/store port, p1 is the auxiliary debug/loader port.
REQ-006 SHALL have ports p0_we and p1_we, input, 1 bit each: 1 = store, 0 = load.
REQ-007 SHALL have ports p0_addr and p1_addr, input, ADDRESS_WIDTH bits each: byte address.
REQ-008 SHALL have ports p0_wdata and p1_wdata, input, DATA_WIDTH bits each: store data.
REQ-009 SHALL have ports p0_funct3 and p1_funct3, input, 3 bits each: size code; 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
REQ-010 SHALL have ports p0_gnt and p1_gnt, output, 1 bit each: request-accepted pulse.
REQ-011 SHALL have ports p0_done and p1_done, output, 1 bit each: completion pulse.
REQ-012 SHALL have ports p0_err and p1_err, output, 1 bit each: access error, valid only while the matching done is high.
REQ-013 SHALL have port rdata, output, DATA_WIDTH bits: load result, valid from the done pulse of a load.
REQ-014 SHALL have memory-side outputs: mem_wr_en (1 bit), mem_addr (ADDRESS_WIDTH), mem_wdata (DATA_WIDTH), mem_funct3 (3 bits).
REQ-015 SHALL have port mem_rdata, input, DATA_WIDTH bits: combinational read data from data memory.

Function
REQ-016 SHALL implement an FSM with three states: IDLE, ACCESS, RESP.
REQ-017 In IDLE with any request high, SHALL select a winner, latch its we/addr/wdata/funct3, pulse that port's gnt combinationally in the same cycle, and go to ACCESS.
REQ-018 Arbitration SHALL be round-robin: a single requester wins; with both requesting, the port not served last wins.
REQ-019 In ACCESS, SHALL drive mem_addr, mem_wdata and mem_funct3 from the latched values; mem_wr_en = latched we AND NOT error; a load SHALL capture mem_rdata into rdata at the edge leaving ACCESS; next state is RESP.
REQ-020 In RESP, SHALL pulse the winner's done (and err if applicable) for one cycle, update the last-served pointer, and return to IDLE.
REQ-021 Latency SHALL be gnt-to-done = 2 cycles; throughput SHALL be one access per 3 cycles.
REQ-022 gnt SHALL NOT assert in ACCESS or RESP; a requester holds req until gnt; inputs may change after gnt without effect.
REQ-023 mem_wr_en SHALL be high for exactly one cycle per non-error store, and never outside ACCESS.
REQ-024 rdata SHALL hold until the next non-error load; stores SHALL NOT alter rdata.
REQ-025 funct3 codes 011, 110 and 111 SHALL be forwarded unchanged and treated as word size for the error check.
REQ-026 A req still high in RESP SHALL be arbitrated on the following IDLE cycle.

Reset
REQ-027 rst SHALL asynchronously force: state IDLE, pointer = p1 (so p0 wins first), latched registers 0, rdata 0, and all gnt/done/err/mem_wr_en outputs 0.
REQ-028 rst during ACCESS SHALL abort the access with no write and no done; the requester must re-request.

Configuration
REQ-029 With DMEM_ARB_ALIGN_CHECK_EN defined, SHALL flag an error when any of these holds: H/HU with addr[0] = 1; W with addr[1:0] != 0; addr + size - 1 >= 2**17. An erroring access performs no write, leaves rdata unchanged, and raises err with done.
REQ-030 Without DMEM_ARB_ALIGN_CHECK_EN, p0_err and p1_err SHALL be tied 0 and every access SHALL reach memory.

Structure
REQ-031 Package dmem_arb_pkg SHALL hold the state enum, the funct3 size constants, DMEM_BYTES = 2**17, and a size-in-bytes function.
REQ-032 The round-robin selection SHALL be sub-module rr_arb2 (inputs req[1:0], last; output onehot grant).

Verification
REQ-033 p0 store W at 0x10000, data 0xDEADBEEF, then load W at the same address -> one mem_wr_en pulse; done 2 cycles after each gnt; rdata = mem_rdata captured.
REQ-034 p0 and p1 both request continuously from reset -> grants alternate p0, p1, p0, p1; each gnt 3 cycles apart.
REQ-035 p1-only load BU at 0x10003 while p0 idle -> p1_gnt same cycle; p1_done 2 cycles later; p0_gnt/p0_done stay 0.
REQ-036 With the macro defined: store H at 0x10001 -> p0_err = 1 with done, mem_wr_en never high; load W at 0x1FFFE -> err, rdata unchanged. Without the macro: the same store H at 0x10001 -> err = 0, mem_wr_en pulses.
REQ-037 rst asserted mid-ACCESS of a store -> mem_wr_en drops immediately, no done; after release, p0 wins the first arbitration.
